// File: rtl/img_pkg.sv
// rtl/img_pkg.sv - shared frame geometry, RGB565 field layout and edge-engine states
package img_pkg;

    localparam int IMG_W  = 150;
    localparam int IMG_H  = 150;
    localparam int ADDR_W = 15;

    localparam int R_MSB = 15;
    localparam int R_LSB = 11;
    localparam int G_MSB = 10;
    localparam int G_LSB = 5;
    localparam int B_MSB = 4;
    localparam int B_LSB = 0;

    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic [3:0] {
        IDLE,
        BORDER_ROW,
        ROW_START,
        PRELOAD,
        FETCH,
        COMPUTE,
        WRITE,
        ROW_END,
        DONE
    } edge_state_t;

endpackage

// File: rtl/rgb565_to_grey.sv
// rtl/rgb565_to_grey.sv - combinational RGB565 to 8-bit grey, weights 1:2:1
module rgb565_to_grey
    import img_pkg::*;
(
    input  logic [15:0] i_rgb,
    output logic [7:0]  o_grey
);

    logic [7:0] w_r8;
    logic [7:0] w_g8;
    logic [7:0] w_b8;
    logic [9:0] w_sum;

    assign w_r8   = {i_rgb[R_MSB:R_LSB], 3'b000};
    assign w_g8   = {i_rgb[G_MSB:G_LSB], 2'b00};
    assign w_b8   = {i_rgb[B_MSB:B_LSB], 3'b000};
    // Worst case 248 + 504 + 248 = 1000, so 10 bits never overflow.
    assign w_sum  = {2'b00, w_r8} + {1'b0, w_g8, 1'b0} + {2'b00, w_b8};
    assign o_grey = w_sum[9:2];

endmodule

// File: rtl/sobel_edge_engine.sv
// rtl/sobel_edge_engine.sv - frame-pass Sobel edge detector from buffer port A to edge map on port B
module sobel_edge_engine #(
    parameter int IMG_W  = img_pkg::IMG_W,
    parameter int IMG_H  = img_pkg::IMG_H,
    parameter int THRESH = 128
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic [img_pkg::ADDR_W-1:0] r_addr_a,
    input  logic [15:0]                d_out_a,
    output logic [img_pkg::ADDR_W-1:0] w_addr_b,
    output logic                       d_in_b,
    output logic                       w_en_b
);
    import img_pkg::*;

    localparam addr_t       L_W    = addr_t'(IMG_W);
    localparam addr_t       L_W2   = addr_t'(2 * IMG_W);
    localparam addr_t       L_W_M1 = addr_t'(IMG_W - 1);
    localparam addr_t       L_W_M2 = addr_t'(IMG_W - 2);
    localparam addr_t       L_H_M1 = addr_t'(IMG_H - 1);
    localparam logic [11:0] L_THR  = 12'(THRESH);

    edge_state_t r_state;
    edge_state_t w_state_nxt;

    addr_t       r_x;
    addr_t       r_y;
    addr_t       r_base_up;
    logic [1:0]  r_ph;
    logic [1:0]  r_rrow;
    logic        r_rcol;
    logic [7:0]  r_win [3][3];

    addr_t       w_col;
    addr_t       w_row_off;
    addr_t       w_rd_addr;
    logic        w_rd_last;
    logic        w_wr_nxt;
    logic [7:0]  w_grey;

    logic [9:0]         w_gx_p;
    logic [9:0]         w_gx_n;
    logic [9:0]         w_gy_p;
    logic [9:0]         w_gy_n;
    logic signed [11:0] w_gx;
    logic signed [11:0] w_gy;
    logic signed [11:0] w_nx;
    logic signed [11:0] w_ny;
    logic [10:0]        w_ax;
    logic [10:0]        w_ay;
    logic [10:0]        w_mag;
    logic               w_edge;

    rgb565_to_grey u_grey (
        .i_rgb  (d_out_a),
        .o_grey (w_grey)
    );

    assign w_rd_last = (r_ph == 2'd2) && (r_rrow == 2'd2) && ((r_state == FETCH) || r_rcol);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:       if (start) w_state_nxt = BORDER_ROW;
            BORDER_ROW: if (r_x == L_W_M1) w_state_nxt = (r_y == '0) ? ROW_START : DONE;
            ROW_START:  w_state_nxt = PRELOAD;
            PRELOAD:    if (w_rd_last) w_state_nxt = FETCH;
            FETCH:      if (w_rd_last) w_state_nxt = COMPUTE;
            COMPUTE:    w_state_nxt = WRITE;
            WRITE:      w_state_nxt = (r_x < L_W_M2) ? FETCH : ROW_END;
            ROW_END:    w_state_nxt = ((r_y + addr_t'(1)) == L_H_M1) ? BORDER_ROW : ROW_START;
            DONE:       w_state_nxt = IDLE;
            default:    w_state_nxt = IDLE;
        endcase
        w_wr_nxt = (w_state_nxt == BORDER_ROW) || (w_state_nxt == ROW_START) ||
                   (w_state_nxt == WRITE)      || (w_state_nxt == ROW_END);
    end

    // Window columns are read top-to-bottom; rows y-1..y+1 sit at base_up + {0, W, 2W}.
    always_comb begin
        w_col = (r_state == PRELOAD) ? addr_t'(r_rcol) : r_x + addr_t'(1);
        case (r_rrow)
            2'd0:    w_row_off = '0;
            2'd1:    w_row_off = L_W;
            default: w_row_off = L_W2;
        endcase
        w_rd_addr = r_base_up + w_col + w_row_off;
    end

    always_comb begin
        w_gx_p = {2'b00, r_win[0][2]} + {1'b0, r_win[1][2], 1'b0} + {2'b00, r_win[2][2]};
        w_gx_n = {2'b00, r_win[0][0]} + {1'b0, r_win[1][0], 1'b0} + {2'b00, r_win[2][0]};
        w_gy_p = {2'b00, r_win[2][0]} + {1'b0, r_win[2][1], 1'b0} + {2'b00, r_win[2][2]};
        w_gy_n = {2'b00, r_win[0][0]} + {1'b0, r_win[0][1], 1'b0} + {2'b00, r_win[0][2]};
        w_gx   = signed'({2'b00, w_gx_p}) - signed'({2'b00, w_gx_n});
        w_gy   = signed'({2'b00, w_gy_p}) - signed'({2'b00, w_gy_n});
        w_nx   = -w_gx;
        w_ny   = -w_gy;
        w_ax   = w_gx[11] ? w_nx[10:0] : w_gx[10:0];
        w_ay   = w_gy[11] ? w_ny[10:0] : w_gy[10:0];
        w_mag  = w_ax + w_ay;
        w_edge = {1'b0, w_mag} > L_THR;
    end

    // Port B outputs are registered from the next state so each write lands in its own state cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            w_en_b    <= 1'b0;
            d_in_b    <= 1'b0;
            r_addr_a  <= '0;
            w_addr_b  <= '0;
            r_x       <= '0;
            r_y       <= '0;
            r_base_up <= '0;
            r_ph      <= '0;
            r_rrow    <= '0;
            r_rcol    <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    r_win[r][c] <= '0;
                end
            end
        end else begin
            busy   <= (w_state_nxt != IDLE) && (w_state_nxt != DONE);
            done   <= (w_state_nxt == DONE);
            w_en_b <= w_wr_nxt;
            d_in_b <= (r_state == COMPUTE) && w_edge;
            if (w_wr_nxt) begin
                w_addr_b <= (r_state == IDLE) ? '0 : w_addr_b + addr_t'(1);
            end

            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_x       <= '0;
                        r_y       <= '0;
                        r_base_up <= '0;
                        r_ph      <= '0;
                        r_rrow    <= '0;
                        r_rcol    <= 1'b0;
                    end
                end
                BORDER_ROW: begin
                    if (r_x == L_W_M1) begin
                        r_x <= '0;
                        r_y <= r_y + addr_t'(1);
                    end else begin
                        r_x <= r_x + addr_t'(1);
                    end
                end
                ROW_START: begin
                    r_ph   <= '0;
                    r_rrow <= '0;
                    r_rcol <= 1'b0;
                end
                PRELOAD, FETCH: begin
                    if (r_ph == 2'd0) begin
                        r_addr_a <= w_rd_addr;
                    end
                    if (r_ph == 2'd2) begin
                        r_ph <= '0;
                        // Each capture shifts its row left, so preload and fetch share one path.
                        for (int r = 0; r < 3; r++) begin
                            if (r_rrow == 2'(r)) begin
                                r_win[r][0] <= r_win[r][1];
                                r_win[r][1] <= r_win[r][2];
                                r_win[r][2] <= w_grey;
                            end
                        end
                        if (r_rrow == 2'd2) begin
                            r_rrow <= '0;
                            r_rcol <= ~r_rcol;
                        end else begin
                            r_rrow <= r_rrow + 2'd1;
                        end
                    end else begin
                        r_ph <= r_ph + 2'd1;
                    end
                    if (w_rd_last && (r_state == PRELOAD)) begin
                        r_x <= addr_t'(1);
                    end
                end
                WRITE: begin
                    if (r_x < L_W_M2) begin
                        r_x <= r_x + addr_t'(1);
                    end
                end
                ROW_END: begin
                    r_x       <= '0;
                    r_y       <= r_y + addr_t'(1);
                    r_base_up <= r_base_up + L_W;
                end
                default: ;
            endcase
        end
    end

endmodule
